// File: rtl/piano_voice_allocator.sv
// Shares NUM_VOICES tone generators among note events: scan for match/free/oldest, then commit.
// Optional build macro VOICE_STEAL_EN: a note-on with every voice busy steals the oldest voice.

module piano_voice_slot #(
  parameter int AGE_W = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             load,
  input  logic             clr,
  input  logic             age_inc,
  input  logic [2:0]       note_oct,
  input  logic [3:0]       note_semi,
  output logic             active,
  output logic [2:0]       oct,
  output logic [3:0]       semi,
  output logic [AGE_W-1:0] age,
  output logic             trig
);
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      active <= 1'b0;
      oct    <= '0;
      semi   <= '0;
      age    <= '0;
      trig   <= 1'b0;
    end else begin
      trig <= load;
      if (load) begin
        active <= 1'b1;
        oct    <= note_oct;
        semi   <= note_semi;
        age    <= '0;
      end else if (clr) begin
        active <= 1'b0;
        age    <= '0;
      end else if (age_inc && active && age != {AGE_W{1'b1}}) begin
        age <= age + 1'b1;
      end
    end
  end
endmodule

module piano_voice_allocator #(
  parameter int NUM_VOICES = 4,
  parameter int AGE_W      = 8
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    ev_valid,
  output logic                    ev_ready,
  input  logic                    ev_note_on,
  input  logic [2:0]              ev_octave,
  input  logic [3:0]              ev_semitone,
  output logic [NUM_VOICES-1:0]   voice_active,
  output logic [3*NUM_VOICES-1:0] voice_octave,
  output logic [4*NUM_VOICES-1:0] voice_semitone,
  output logic [NUM_VOICES-1:0]   voice_trig,
  output logic                    busy,
  output logic [7:0]              drop_count
);
  localparam int IDX_W = $clog2(NUM_VOICES);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_VOICES - 1);

  typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;

  state_t                             state;
  logic [IDX_W-1:0]                   idx;
  logic                               on_q;
  logic [2:0]                         oct_q;
  logic [3:0]                         semi_q;
  logic                               match_vld, free_vld;
  logic [IDX_W-1:0]                   match_idx, free_idx;
  logic [NUM_VOICES-1:0][2:0]         v_oct;
  logic [NUM_VOICES-1:0][3:0]         v_semi;
  logic [NUM_VOICES-1:0][AGE_W-1:0]   v_age;
  logic                               tgt_vld, do_clr, do_drop;
  logic [IDX_W-1:0]                   tgt_idx;
  logic                               commit;

  assign voice_octave   = v_oct;
  assign voice_semitone = v_semi;
  assign ev_ready       = (state == IDLE);
  assign busy           = ~ev_ready;
  assign commit         = (state == COMMIT);

`ifdef VOICE_STEAL_EN
  logic             old_vld;
  logic [IDX_W-1:0] old_idx;
  logic [AGE_W-1:0] old_age;
`else
  logic unused_age;
  assign unused_age = ^v_age;
`endif

  always_comb begin
    tgt_vld = 1'b0;
    tgt_idx = '0;
    do_clr  = 1'b0;
    do_drop = 1'b0;
    if (semi_q >= 4'd12) begin
      do_drop = 1'b1;
    end else if (on_q) begin
      if (match_vld) begin
        tgt_vld = 1'b1;
        tgt_idx = match_idx;
      end else if (free_vld) begin
        tgt_vld = 1'b1;
        tgt_idx = free_idx;
      end else begin
`ifdef VOICE_STEAL_EN
        tgt_vld = old_vld;
        tgt_idx = old_idx;
`else
        do_drop = 1'b1;
`endif
      end
    end else begin
      do_clr = match_vld;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      idx        <= '0;
      on_q       <= 1'b0;
      oct_q      <= '0;
      semi_q     <= '0;
      match_vld  <= 1'b0;
      match_idx  <= '0;
      free_vld   <= 1'b0;
      free_idx   <= '0;
      drop_count <= '0;
`ifdef VOICE_STEAL_EN
      old_vld    <= 1'b0;
      old_idx    <= '0;
      old_age    <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (ev_valid) begin
          on_q      <= ev_note_on;
          oct_q     <= ev_octave;
          semi_q    <= ev_semitone;
          idx       <= '0;
          match_vld <= 1'b0;
          free_vld  <= 1'b0;
`ifdef VOICE_STEAL_EN
          old_vld   <= 1'b0;
`endif
          state     <= SCAN;
        end
        SCAN: begin
          // First hit wins, so match and free both resolve to the lowest index.
          if (voice_active[idx] && v_oct[idx] == oct_q && v_semi[idx] == semi_q && !match_vld) begin
            match_vld <= 1'b1;
            match_idx <= idx;
          end
          if (!voice_active[idx] && !free_vld) begin
            free_vld <= 1'b1;
            free_idx <= idx;
          end
`ifdef VOICE_STEAL_EN
          if (voice_active[idx] && (!old_vld || v_age[idx] > old_age)) begin
            old_vld <= 1'b1;
            old_idx <= idx;
            old_age <= v_age[idx];
          end
`endif
          if (idx == LAST) state <= COMMIT;
          else             idx   <= idx + 1'b1;
        end
        COMMIT: begin
          if (do_drop && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < NUM_VOICES; i++) begin : g_voice
    logic hit;
    assign hit = tgt_vld && tgt_idx == IDX_W'(i);
    piano_voice_slot #(.AGE_W(AGE_W)) u_slot (
      .clk       (clk),
      .resetn    (resetn),
      .load      (commit && hit),
      .clr       (commit && do_clr && match_idx == IDX_W'(i)),
      .age_inc   (commit && tgt_vld && !hit),
      .note_oct  (oct_q),
      .note_semi (semi_q),
      .active    (voice_active[i]),
      .oct       (v_oct[i]),
      .semi      (v_semi[i]),
      .age       (v_age[i]),
      .trig      (voice_trig[i])
    );
  end
endmodule

// File: tb/tb_piano_voice_allocator.sv
// Directed + random bench for piano_voice_allocator against a note-table reference model.
module tb_piano_voice_allocator;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           resetn = 1'b0;
  logic           ev_valid = 1'b0;
  logic           ev_ready;
  logic           ev_note_on = 1'b0;
  logic [2:0]     ev_octave = '0;
  logic [3:0]     ev_semitone = '0;
  logic [N-1:0]   voice_active;
  logic [3*N-1:0] voice_octave;
  logic [4*N-1:0] voice_semitone;
  logic [N-1:0]   voice_trig;
  logic           busy;
  logic [7:0]     drop_count;

  int n_assert = 0;
  int n_fail = 0;

  // reference model: plain per-voice table
  bit m_act[N];
  int m_oct[N], m_semi[N], m_age[N];
  int m_drop;

  always #5 clk = ~clk;

  piano_voice_allocator #(.NUM_VOICES(N), .AGE_W(8)) dut (
    .clk(clk), .resetn(resetn), .ev_valid(ev_valid), .ev_ready(ev_ready),
    .ev_note_on(ev_note_on), .ev_octave(ev_octave), .ev_semitone(ev_semitone),
    .voice_active(voice_active), .voice_octave(voice_octave), .voice_semitone(voice_semitone),
    .voice_trig(voice_trig), .busy(busy), .drop_count(drop_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_act[i] = 0; m_oct[i] = 0; m_semi[i] = 0; m_age[i] = 0;
    end
    m_drop = 0;
  endtask

  task automatic model_drop();
    if (m_drop < 255) m_drop++;
  endtask

  task automatic model_event(input bit on, input int o, input int s, output logic [N-1:0] trig);
    int m, f, old, t;
    trig = '0;
    if (s >= 12) begin
      model_drop();
      return;
    end
    m = -1; f = -1; old = -1;
    for (int i = 0; i < N; i++) begin
      if (m_act[i] && m_oct[i] == o && m_semi[i] == s && m < 0) m = i;
      if (!m_act[i] && f < 0) f = i;
      if (m_act[i] && (old < 0 || m_age[i] > m_age[old])) old = i;
    end
    if (on) begin
      t = (m >= 0) ? m : (f >= 0) ? f : -1;
`ifdef VOICE_STEAL_EN
      if (t < 0) t = old;
`endif
      if (t < 0) model_drop();
      else begin
        for (int i = 0; i < N; i++)
          if (m_act[i] && i != t && m_age[i] < 255) m_age[i]++;
        m_act[t] = 1; m_oct[t] = o; m_semi[t] = s; m_age[t] = 0;
        trig[t] = 1'b1;
      end
    end else if (m >= 0) begin
      m_act[m] = 0; m_age[m] = 0;
    end
  endtask

  task automatic check_state(input string tag);
    logic [N-1:0]   ea;
    logic [3*N-1:0] eo;
    logic [4*N-1:0] es;
    for (int i = 0; i < N; i++) begin
      ea[i] = m_act[i];
      eo[3*i +: 3] = 3'(m_oct[i]);
      es[4*i +: 4] = 4'(m_semi[i]);
    end
    chk({tag, "_active"}, voice_active, ea);
    chk({tag, "_octave"}, voice_octave, eo);
    chk({tag, "_semitone"}, voice_semitone, es);
    chk({tag, "_drop"}, drop_count, m_drop);
  endtask

  // Full handshake; verifies busy window, trig pulse and resulting voice table.
  task automatic send(input string tag, input bit on, input int o, input int s, input bit full_chk);
    logic [N-1:0] etrig;
    int n;
    @(negedge clk);
    ev_valid = 1'b1; ev_note_on = on; ev_octave = 3'(o); ev_semitone = 4'(s);
    @(posedge clk); #1;
    ev_valid = 1'b0;
    model_event(on, o, s, etrig);
    n = 0;
    @(negedge clk);
    while (!ev_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (full_chk) begin
      chk({tag, "_busy_cycles"}, n, N + 1);
      chk({tag, "_trig"}, voice_trig, etrig);
      check_state(tag);
      @(negedge clk);
      chk({tag, "_trig_clear"}, voice_trig, '0);
    end else if (n != N + 1) begin
      chk({tag, "_busy_cycles"}, n, N + 1);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk); #2;
    resetn = 1'b0;
    @(negedge clk);
    chk("rst_ready", {ev_ready, busy}, 2'b10);
    resetn = 1'b1;
    model_reset();
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    chk("reset_ready", {ev_ready, busy}, 2'b10);
    chk("reset_trig", voice_trig, '0);
    check_state("reset");

    send("on49", 1, 4, 9, 1);
    chk("on49_v0", {voice_active, voice_octave[2:0], voice_semitone[3:0]}, {4'b0001, 3'd4, 4'd9});
    send("on49_again", 1, 4, 9, 1);

    pulse_reset();
    check_state("midrun_reset");

    send("fill_c", 1, 4, 0, 1);
    send("fill_d", 1, 4, 2, 1);
    send("fill_e", 1, 4, 4, 1);
    send("fill_f", 1, 4, 5, 1);
    send("on_g_full", 1, 4, 7, 1);
`ifdef VOICE_STEAL_EN
    chk("steal_v0", voice_semitone[3:0], 4'd7);
`else
    chk("nosteal_drop", drop_count, 8'd1);
`endif
    send("off_d", 0, 4, 2, 1);
    send("on_a", 1, 4, 9, 1);
    chk("reuse_v1", {voice_active, voice_semitone[7:4]}, {4'b1111, 4'd9});
    send("off_unplayed", 0, 2, 11, 1);
    send("illegal13", 1, 4, 13, 1);

    for (int k = 0; k < 200; k++)
      send("rand", $urandom_range(0, 2) != 0, $urandom_range(3, 4), $urandom_range(0, 13), 1);

    // reset landing during SCAN discards the in-flight event
    @(negedge clk);
    ev_valid = 1'b1; ev_note_on = 1'b1; ev_octave = 3'd5; ev_semitone = 4'd1;
    @(posedge clk); #1;
    ev_valid = 1'b0;
    @(negedge clk);
    chk("scan_busy", {ev_ready, busy}, 2'b01);
    #2 resetn = 1'b0;
    #1 chk("scan_rst_ready", ev_ready, 1'b1);
    @(negedge clk);
    resetn = 1'b1;
    model_reset();
    @(negedge clk);
    check_state("scan_rst");
    chk("scan_rst_trig", voice_trig, '0);

    for (int k = 0; k < 300; k++)
      send("ill", 1, $urandom_range(0, 7), $urandom_range(12, 15), 0);
    check_state("sat");
    chk("drop_sat", drop_count, 8'd255);
    send("post_sat", 0, 1, 14, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #20ms;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
endmodule
